// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and widths for the memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam int WIDX_W    = 3;
    localparam int BLK_OFF_W = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and memory-side bundle of the memory arbiter
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) ();

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_grant;
    logic              i_data_valid;
    logic [DATA_W-1:0] i_data;
    logic [WIDX_W-1:0] i_word_idx;
    logic              i_done;

    logic              d_req;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_grant;
    logic              d_data_valid;
    logic [DATA_W-1:0] d_data;
    logic [WIDX_W-1:0] d_word_idx;
    logic              d_done;

    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;
    logic              mem_data_valid;

    modport slave (
        input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_data_out, mem_data_valid,
        output i_grant, i_data_valid, i_data, i_word_idx, i_done,
        output d_grant, d_data_valid, d_data, d_word_idx, d_done,
        output mem_en, mem_wr, mem_addr, mem_data_in
    );

    modport master (
        output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_data_out, mem_data_valid,
        input  i_grant, i_data_valid, i_data, i_word_idx, i_done,
        input  d_grant, d_data_valid, d_data, d_word_idx, d_done,
        input  mem_en, mem_wr, mem_addr, mem_data_in
    );

endinterface

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - two-way request picker; MEM_ARB_RR_EN turns ties into round-robin
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   i_req,
    input  logic   d_req,
    input  owner_t last,
    output logic   pick_valid,
    output owner_t pick_owner
);

`ifdef MEM_ARB_RR_EN
    always_comb begin
        pick_valid = i_req | d_req;
        if (i_req && d_req)
            pick_owner = (last == OWN_I) ? OWN_D : OWN_I;
        else
            pick_owner = d_req ? OWN_D : OWN_I;
    end
`else
    logic unused_last;
    assign unused_last = last;

    always_comb begin
        pick_valid = i_req | d_req;
        pick_owner = d_req ? OWN_D : OWN_I;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares pipelined main memory between I/D miss handlers (MEM_ARB_RR_EN: round-robin ties)
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 16,
    parameter int WORDS_PER_BLK = 8,
    parameter int MEM_LAT       = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    localparam logic [WIDX_W:0]   BLK_CNT        = (WIDX_W+1)'(WORDS_PER_BLK);
    localparam logic [WIDX_W-1:0] LAST_RCV       = WIDX_W'(WORDS_PER_BLK - 1);
    localparam int                unused_mem_lat = MEM_LAT;

    arb_state_t                  state, state_nxt;
    owner_t                      owner, owner_nxt;
    logic [ADDR_W-BLK_OFF_W-1:0] tag_q, tag_nxt;
    logic [WIDX_W:0]             k, k_nxt;
    logic [WIDX_W-1:0]           rcv, rcv_nxt;
    logic                        en_q, en_nxt, wr_q, wr_nxt;
    logic [ADDR_W-1:0]           addr_q, addr_nxt;
    logic [DATA_W-1:0]           din_q, din_nxt;
    logic                        pick_valid;
    owner_t                      pick_owner;
    logic                        grant, fill_valid, done;
    logic                        unused_low;

    assign unused_low = ^bus.i_addr[BLK_OFF_W-1:0];

    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-BLK_OFF_W-1:0] tag,
                                                    input logic [WIDX_W-1:0]           idx);
        return {tag, idx, 1'b0};
    endfunction

    mem_arb_pick u_pick (
        .i_req      (bus.i_req),
        .d_req      (bus.d_req),
        .last       (owner),
        .pick_valid (pick_valid),
        .pick_owner (pick_owner)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            owner  <= OWN_I;
            tag_q  <= '0;
            k      <= '0;
            rcv    <= '0;
            en_q   <= 1'b0;
            wr_q   <= 1'b0;
            addr_q <= '0;
            din_q  <= '0;
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            tag_q  <= tag_nxt;
            k      <= k_nxt;
            rcv    <= rcv_nxt;
            en_q   <= en_nxt;
            wr_q   <= wr_nxt;
            addr_q <= addr_nxt;
            din_q  <= din_nxt;
        end
    end

    // mem_* are computed one cycle ahead so the registered outputs line up with state
    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        tag_nxt    = tag_q;
        k_nxt      = k;
        rcv_nxt    = rcv;
        en_nxt     = 1'b0;
        wr_nxt     = 1'b0;
        addr_nxt   = addr_q;
        din_nxt    = din_q;
        grant      = 1'b0;
        fill_valid = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                k_nxt   = '0;
                rcv_nxt = '0;
                if (pick_valid) begin
                    owner_nxt = pick_owner;
                    en_nxt    = 1'b1;
                    if (pick_owner == OWN_D && bus.d_wr) begin
                        state_nxt = WRITE;
                        wr_nxt    = 1'b1;
                        addr_nxt  = bus.d_addr;
                        din_nxt   = bus.d_wdata;
                    end else begin
                        state_nxt = FILL;
                        tag_nxt   = (pick_owner == OWN_D) ? bus.d_addr[ADDR_W-1:BLK_OFF_W]
                                                          : bus.i_addr[ADDR_W-1:BLK_OFF_W];
                        addr_nxt  = word_addr(tag_nxt, '0);
                        k_nxt     = (WIDX_W+1)'(1);
                    end
                end
            end
            FILL: begin
                grant = 1'b1;
                if (k < BLK_CNT) begin
                    en_nxt   = 1'b1;
                    addr_nxt = word_addr(tag_q, k[WIDX_W-1:0]);
                    k_nxt    = k + 1'b1;
                end
                if (bus.mem_data_valid) begin
                    fill_valid = 1'b1;
                    rcv_nxt    = rcv + 1'b1;
                    if (rcv == LAST_RCV) begin
                        done      = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            WRITE: begin
                grant     = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.i_grant      = grant && (owner == OWN_I);
    assign bus.d_grant      = grant && (owner == OWN_D);
    assign bus.i_done       = done && (owner == OWN_I);
    assign bus.d_done       = done && (owner == OWN_D);
    assign bus.i_data_valid = fill_valid && (owner == OWN_I);
    assign bus.d_data_valid = fill_valid && (owner == OWN_D);
    assign bus.i_data       = bus.i_data_valid ? bus.mem_data_out : '0;
    assign bus.d_data       = bus.d_data_valid ? bus.mem_data_out : '0;
    assign bus.i_word_idx   = bus.i_data_valid ? rcv : '0;
    assign bus.d_word_idx   = bus.d_data_valid ? rcv : '0;

    assign bus.mem_en      = en_q;
    assign bus.mem_wr      = wr_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_data_in = din_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized bench for mem_arbiter with a cycle-schedule reference model
module tb_mem_arbiter;

    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WORDS_PER_BLK(8), .MEM_LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] init_word(input logic [15:0] a);
        logic [15:0] t;
        t = a * 16'h9E37;
        return t ^ 16'h5A5A;
    endfunction

    // Memory environment: fixed-latency pipelined reads, writes into a sparse store
    logic [15:0] env_mem [int];
    logic [15:0] mdl_mem [int];
    bit          sv [16];
    logic [15:0] sd [16];
    bit          stray = 1'b0;

    function automatic logic [15:0] env_rd(input logic [15:0] a);
        int key;
        key = int'(a[15:1]);
        return env_mem.exists(key) ? env_mem[key] : init_word({a[15:1], 1'b0});
    endfunction

    function automatic logic [15:0] mdl_rd(input logic [15:0] a);
        int key;
        key = int'(a[15:1]);
        return mdl_mem.exists(key) ? mdl_mem[key] : init_word({a[15:1], 1'b0});
    endfunction

    always @(posedge clk) begin
        #1;
        cyc++;
        bus.mem_data_valid = sv[cyc % 16] | stray;
        bus.mem_data_out   = sv[cyc % 16] ? sd[cyc % 16] : 16'($urandom);
        sv[cyc % 16]       = 1'b0;
    end

    always @(negedge clk) begin
        if (bus.mem_en === 1'b1) begin
            if (bus.mem_wr === 1'b1)
                env_mem[int'(bus.mem_addr[15:1])] = bus.mem_data_in;
            else begin
                sv[(cyc + LAT) % 16] = 1'b1;
                sd[(cyc + LAT) % 16] = env_rd(bus.mem_addr);
            end
        end
    end

    // Reference model: a transaction is a schedule indexed by cycles since grant
    int          m_busy = 0;
    int          m_t    = 0;
    bit          m_own  = 1'b0;
    bit          m_last_d = 1'b0;
    bit          m_post_rst = 1'b0;
    bit          model_ok = 1'b0;
    bit          m_wi, m_wd, m_win_d;
    logic [15:0] m_base, m_waddr, m_wdata;
    logic        e_ig = 0, e_dg = 0, e_iv = 0, e_dv = 0, e_idn = 0, e_ddn = 0, e_en = 0, e_wr = 0;
    logic [15:0] e_addr, e_din, e_data;
    logic [2:0]  e_idx;

    always @(negedge clk) begin
        e_ig = 0; e_dg = 0; e_iv = 0; e_dv = 0; e_idn = 0; e_ddn = 0; e_en = 0; e_wr = 0;
        e_addr = '0; e_din = '0; e_data = '0; e_idx = '0;
        if (model_ok) begin
            if (m_busy == 1) begin
                if (m_own) e_dg = 1; else e_ig = 1;
                if (m_t <= 8) begin
                    e_en   = 1;
                    e_addr = m_base + 16'(2 * (m_t - 1));
                end
                if (m_t > LAT && m_t <= LAT + 8) begin
                    e_idx  = 3'(m_t - LAT - 1);
                    e_data = mdl_rd(m_base + 16'(2 * (m_t - LAT - 1)));
                    if (m_own) e_dv = 1; else e_iv = 1;
                    if (m_t == LAT + 8) begin
                        if (m_own) e_ddn = 1; else e_idn = 1;
                    end
                end
            end else if (m_busy == 2) begin
                e_dg = 1; e_en = 1; e_wr = 1; e_ddn = 1;
                e_addr = m_waddr;
                e_din  = m_wdata;
            end
            chk("i_grant", 32'(bus.i_grant), 32'(e_ig));
            chk("d_grant", 32'(bus.d_grant), 32'(e_dg));
            chk("i_data_valid", 32'(bus.i_data_valid), 32'(e_iv));
            chk("d_data_valid", 32'(bus.d_data_valid), 32'(e_dv));
            chk("i_done", 32'(bus.i_done), 32'(e_idn));
            chk("d_done", 32'(bus.d_done), 32'(e_ddn));
            chk("mem_en", 32'(bus.mem_en), 32'(e_en));
            chk("mem_wr", 32'(bus.mem_wr), 32'(e_wr));
            if (e_en || m_post_rst) chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
            if (e_wr || m_post_rst) chk("mem_data_in", 32'(bus.mem_data_in), 32'(e_din));
            if (e_iv || m_post_rst) begin
                chk("i_data", 32'(bus.i_data), 32'(e_iv ? e_data : 16'h0));
                chk("i_word_idx", 32'(bus.i_word_idx), 32'(e_idx));
            end
            if (e_dv || m_post_rst) begin
                chk("d_data", 32'(bus.d_data), 32'(e_dv ? e_data : 16'h0));
                chk("d_word_idx", 32'(bus.d_word_idx), 32'(e_idx));
            end
        end
        if (rst) begin
            m_busy = 0; m_last_d = 1'b0; m_post_rst = 1'b1; model_ok = 1'b1;
        end else if (model_ok) begin
            m_post_rst = 1'b0;
            if (m_busy == 0) begin
                m_wi = (bus.i_req === 1'b1);
                m_wd = (bus.d_req === 1'b1);
`ifdef MEM_ARB_RR_EN
                m_win_d = (m_wi && m_wd) ? !m_last_d : m_wd;
`else
                m_win_d = m_wd;
`endif
                if (m_wi || m_wd) begin
                    m_t = 1; m_own = m_win_d; m_last_d = m_win_d;
                    if (m_win_d && bus.d_wr) begin
                        m_busy = 2; m_waddr = bus.d_addr; m_wdata = bus.d_wdata;
                    end else begin
                        m_busy = 1;
                        m_base = (m_win_d ? bus.d_addr : bus.i_addr) & 16'hFFF0;
                    end
                end
            end else if (m_busy == 1) begin
                if (m_t == LAT + 8) m_busy = 0; else m_t++;
            end else begin
                mdl_mem[int'(m_waddr[15:1])] = m_wdata;
                m_busy = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // mode 0: finish current request then stay quiet; 1: re-request back-to-back; 2: random
    task automatic step(input int im, input int dm);
        if (bus.i_req) begin
            if (e_idn) begin
                if (im == 1 || (im == 2 && $urandom_range(1, 0) == 1)) bus.i_addr = 16'($urandom);
                else bus.i_req = 1'b0;
            end else if (im == 2 && $urandom_range(39, 0) == 0) bus.i_req = 1'b0;
        end else if (im == 1 || (im == 2 && $urandom_range(3, 0) == 0)) begin
            bus.i_req = 1'b1; bus.i_addr = 16'($urandom);
        end
        if (bus.d_req && !e_ddn) begin
            if (dm == 2 && $urandom_range(39, 0) == 0) bus.d_req = 1'b0;
        end else if ((bus.d_req && e_ddn && dm == 0) || (!bus.d_req && dm == 0)) begin
            bus.d_req = 1'b0;
        end else if (dm == 1 || (dm == 2 && $urandom_range(2, 0) == 0)) begin
            bus.d_req   = 1'b1;
            bus.d_wr    = (dm == 2) ? 1'($urandom_range(1, 0)) : 1'b0;
            bus.d_addr  = 16'($urandom) & 16'hFFFE;
            bus.d_wdata = 16'($urandom);
        end else bus.d_req = 1'b0;
    endtask

    task automatic run(input int n, input int im, input int dm);
        repeat (n) begin
            tick();
            step(im, dm);
        end
    endtask

    task automatic do_reset();
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
    endtask

    int gs[$];
    bit prev_ig, prev_dg;

    initial begin
        bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_wr = 0; bus.d_addr = 0; bus.d_wdata = 0;
        repeat (3) tick();
        rst = 1'b0;
        #4;
        chk("rst_i_grant", 32'(bus.i_grant), 32'd0);
        chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        run(2, 0, 0);

        // I fill at 0x1236
        tick(); bus.i_req = 1; bus.i_addr = 16'h1236;
        for (int j = 1; j <= 13; j++) begin
            tick();
            if (j == 13) bus.i_req = 0;
            #4;
            if (j == 1) begin
                chk("ifill_grant_t1", 32'(bus.i_grant), 32'd1);
                chk("ifill_addr_t1", 32'(bus.mem_addr), 32'h1230);
            end
            if (j == 8) chk("ifill_addr_t8", 32'(bus.mem_addr), 32'h123E);
            if (j == 9) chk("ifill_en_t9", 32'(bus.mem_en), 32'd0);
            if (j == 5) begin
                chk("ifill_valid_t5", 32'(bus.i_data_valid), 32'd1);
                chk("ifill_idx_t5", 32'(bus.i_word_idx), 32'd0);
                chk("ifill_data_t5", 32'(bus.i_data), 32'(init_word(16'h1230)));
            end
            if (j == 12) begin
                chk("ifill_done_t12", 32'(bus.i_done), 32'd1);
                chk("ifill_idx_t12", 32'(bus.i_word_idx), 32'd7);
            end
            if (j == 13) chk("ifill_grant_t13", 32'(bus.i_grant), 32'd0);
        end

        // D write 0xBEEF to 0x0040
        tick(); bus.d_req = 1; bus.d_wr = 1; bus.d_addr = 16'h0040; bus.d_wdata = 16'hBEEF;
        for (int j = 1; j <= 2; j++) begin
            tick();
            if (j == 2) bus.d_req = 0;
            #4;
            if (j == 1) begin
                chk("dwr_en", 32'(bus.mem_en), 32'd1);
                chk("dwr_wr", 32'(bus.mem_wr), 32'd1);
                chk("dwr_addr", 32'(bus.mem_addr), 32'h0040);
                chk("dwr_din", 32'(bus.mem_data_in), 32'hBEEF);
                chk("dwr_done", 32'(bus.d_done), 32'd1);
            end else chk("dwr_done_t2", 32'(bus.d_done), 32'd0);
        end

        // Simultaneous fills: D first, I one bubble after d_done
        do_reset();
        tick(); bus.i_req = 1; bus.i_addr = 16'h2000; bus.d_req = 1; bus.d_wr = 0; bus.d_addr = 16'h3008;
        for (int j = 1; j <= 14; j++) begin
            tick();
            if (j == 13) bus.d_req = 0;
            #4;
            if (j == 1) begin
                chk("tie_d_grant", 32'(bus.d_grant), 32'd1);
                chk("tie_i_wait", 32'(bus.i_grant), 32'd0);
            end
            if (j == 12) chk("tie_d_done", 32'(bus.d_done), 32'd1);
            if (j == 13) chk("tie_bubble", 32'({bus.i_grant, bus.d_grant}), 32'd0);
            if (j == 14) chk("tie_i_grant", 32'(bus.i_grant), 32'd1);
        end
        run(16, 0, 0);

        // Back-to-back ties: grant order
        do_reset();
        prev_ig = 0; prev_dg = 0;
        for (int j = 0; j < 40; j++) begin
            tick();
            step(1, 1);
            #4;
            if (bus.i_grant && !prev_ig) gs.push_back(0);
            if (bus.d_grant && !prev_dg) gs.push_back(1);
            prev_ig = bus.i_grant; prev_dg = bus.d_grant;
        end
        chk("order_count", 32'(gs.size() >= 3), 32'd1);
        if (gs.size() >= 3) begin
            chk("order_0", 32'(gs[0]), 32'd1);
`ifdef MEM_ARB_RR_EN
            chk("order_1", 32'(gs[1]), 32'd0);
`else
            chk("order_1", 32'(gs[1]), 32'd1);
`endif
            chk("order_2", 32'(gs[2]), 32'd1);
        end
        run(40, 0, 0);

        // Reset during cycle T+6 of an I fill
        tick(); bus.i_req = 1; bus.i_addr = 16'h4567;
        for (int j = 1; j <= 11; j++) begin
            tick();
            if (j == 6) begin rst = 1; bus.i_req = 0; end
            if (j == 7) rst = 0;
            #4;
            if (j == 7) begin
                chk("rstmid_grant", 32'({bus.i_grant, bus.d_grant}), 32'd0);
                chk("rstmid_en", 32'({bus.mem_en, bus.mem_wr}), 32'd0);
                chk("rstmid_addr", 32'(bus.mem_addr), 32'd0);
                chk("rstmid_din", 32'(bus.mem_data_in), 32'd0);
            end
            if (j >= 7) chk("rstmid_stale", 32'(bus.i_data_valid), 32'd0);
        end
        tick(); bus.d_req = 1; bus.d_wr = 0; bus.d_addr = 16'h0046;
        for (int j = 1; j <= 5; j++) begin
            tick();
            #4;
            if (j == 5) begin
                chk("post_rst_dv", 32'(bus.d_data_valid), 32'd1);
                chk("post_rst_data", 32'(bus.d_data), 32'hBEEF);
                chk("post_rst_idx", 32'(bus.d_word_idx), 32'd0);
            end
        end
        run(16, 0, 0);

        // Stray valids while idle
        tick(); stray = 1'b1;
        for (int j = 1; j <= 3; j++) begin
            tick();
            #4;
            chk("stray_dv", 32'({bus.i_data_valid, bus.d_data_valid}), 32'd0);
            chk("stray_done", 32'({bus.i_done, bus.d_done}), 32'd0);
        end
        tick(); stray = 1'b0;
        run(6, 0, 0);

        run(3000, 2, 2);
        run(60, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single shared, pipelined, unified main memory between the instruction-cache and data-cache miss handlers of the `cpu` core. Each granted transaction is one of two kinds: an 8-word block fill (either side) or a single-word write-through (D-side only). The block drives `mem_en`/`mem_wr`/`mem_addr`/`mem_data_in` and routes `mem_data_out` words, tagged with their word index, back to the owning requester. It sits between the two cache controllers and the memory model, inside `cpu`.

## Interface
- `ADDR_W`, 16, byte-address width
- `DATA_W`, 16, word width
- `WORDS_PER_BLK`, 8, words per cache block (power of two)
- `MEM_LAT`, 4, memory read latency in cycles, fixed and pipelined
- `clk` in 1: the single clock; every flop updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `i_req` in 1: I-side fill request; held until `i_done`.
- `i_addr` in ADDR_W: I-side miss address; the low 4 bits are ignored.
- `i_grant` out 1: the I-side owns the memory.
- `i_data_valid` out 1: `i_data` carries a fill word this cycle.
- `i_data` out DATA_W: fill word.
- `i_word_idx` out 3: index of the fill word within the block.
- `i_done` out 1: one-cycle pulse when the I-side transaction ends.
- `d_req` in 1: D-side request; held until `d_done`.
- `d_wr` in 1: 1 = single-word write, 0 = block fill.
- `d_addr` in ADDR_W: D-side address (word-aligned for writes).
- `d_wdata` in DATA_W: write data.
- `d_grant`, `d_data_valid`, `d_data`, `d_word_idx`, `d_done`: out, same widths as the I-side equivalents; D-side counterparts of those signals.
- `mem_en` out 1: memory enable.
- `mem_wr` out 1: memory write strobe.
- `mem_addr` out ADDR_W: memory address.
- `mem_data_in` out DATA_W: write data sent to memory.
- `mem_data_out` in DATA_W: read data returned by memory.
- `mem_data_valid` in 1: `mem_data_out` is valid this cycle.

## Operation
- **States:** IDLE, FILL, WRITE. Owner register holds I or D.
- **IDLE:**
  - Samples requests each cycle.
  - On a winning request the block latches the owner and the address, and for a D-side write also the write data.
  - Next state is WRITE when the D-side wins with `d_wr`=1; otherwise FILL.
- **FILL:**
  - Issue counter k runs from 0 to 7.
  - Each cycle with k<8 drives `mem_en`=1, `mem_wr`=0, `mem_addr`={base[15:4], k[2:0], 1'b0}.
  - A separate receive counter advances on each `mem_data_valid`.
  - On each valid, the owner's data_valid, data and word_idx (= receive count) are asserted.
  - The 8th valid pulses the owner's done in the same cycle; the next state is IDLE.
- **WRITE:**
  - One cycle with `mem_en`=1, `mem_wr`=1, `mem_addr`=latched address, `mem_data_in`=latched write data.
  - `d_done` pulses in the same cycle; the next state is IDLE.
- **Grant:** the owner's grant is high for every cycle in FILL/WRITE, including the done cycle.
- **Arbitration:** fixed priority with the D-side first, unless the round-robin build option (see Configuration) is compiled in.
- **Boundary cases:**
  - A requester dropping req mid-transaction is ignored; the transaction completes.
  - `mem_data_valid` while in IDLE or WRITE is discarded.
  - Valids beyond the 8th are impossible by construction and are ignored.
  - The non-owner's data_valid and done stay 0.
- **Reset:**
  - Outputs reset to 0: all grant, done and data_valid outputs, `mem_en`, `mem_wr`, `mem_addr`, `mem_data_in`, data and word_idx.
  - State returns to IDLE, owner to I, and both counters to 0.
  - Reset mid-FILL abandons the transaction; in-flight returns arriving afterwards are discarded.

## Timing
- A request sampled in IDLE at edge T gives grant=1 and the first `mem_en` in cycle T+1.
- A fill issues addresses in T+1..T+8 and returns data in T+1+MEM_LAT..T+8+MEM_LAT. Done pulses in T+8+MEM_LAT, which is T+12 at the defaults.
- A write has `mem_en`/`mem_wr`/`d_done` in T+1.
- The block is back in IDLE the cycle after done. It can sample a new request there, so there is one bubble between transactions.
- `mem_*` outputs are registered.

## Configuration
- `MEM_ARB_RR_EN` defined:
  - On simultaneous requests, the side not granted last wins.
  - The last-granted register resets to I, so the D-side wins the first tie.
  - A single requester always wins.
- `MEM_ARB_RR_EN` undefined: the D-side always wins ties.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum (IDLE/FILL/WRITE);
  - the owner enum (OWN_I/OWN_D);
  - the localparams for the word-index width and the block-offset width (4).
- Sub-module `mem_arb_pick` is a combinational two-way picker. Inputs: `i_req`, `d_req`, last-granted. Outputs: `pick_valid`, `pick_owner`. The round-robin macro is confined to this sub-module.

## Test plan
- **I fill:** `i_req`=1, `i_addr`=0x1236.
  - `mem_addr` 0x1230,0x1232,…,0x123E in T+1..T+8.
  - `i_word_idx` 0..7 in T+5..T+12.
  - `i_done` in T+12.
- **D write:** `d_req`=1, `d_wr`=1, `d_addr`=0x0040, `d_wdata`=0xBEEF.
  - T+1: `mem_en`=`mem_wr`=1, `mem_addr`=0x0040, `mem_data_in`=0xBEEF, `d_done`=1.
- **Simultaneous fills, fixed priority:** `i_req` and `d_req` both asserted.
  - The D-side is granted first.
  - I is granted the cycle after `d_done`+1.
  - No interleaved data.
- **Round-robin build:** two back-to-back ties.
  - Grants go D, then I, then D.
- **Reset at T+6 of a fill:**
  - All outputs are 0 next cycle.
  - Stale `mem_data_valid` produces no `i_data_valid`.
  - A new `d_req` is served normally.
- **Stray `mem_data_valid` in IDLE:**
  - No data_valid or done on either side.
